ibr_pipe_addsub: RTL and testbench
==================================

// Module: ibr_pipe_addsub
// PURPOSE
//  Parametrised carry-segmented pipelined adder/subtractor for the wide-word datapaths (Blowfish128, RECTANGLE
//  key/round arithmetic). One operand pair is accepted per cycle. The sum is produced mod 2^WIDTH.
//  Operand skew is handled internally, so every segment of a result belongs to the same transaction.
//  Adds a per-transaction add/sub mode, carry/borrow out, and valid/ready flow control with backpressure.
// PARAMETERS
//  WIDTH   128  operand/result width in bits; must be a multiple of SEG_W
//  SEG_W   16   bits resolved per pipeline stage; NSEG = WIDTH/SEG_W stages (localparam, NSEG >= 1)
// PORTS
//  Clk        in   1      single clock, all logic on posedge
//  Rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair and mode are valid this cycle
//  in_ready   out  1      block accepts the pair this cycle (transfer = in_valid & in_ready)
//  in_sub     in   1      0: S = A + B; 1: S = A - B
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  out_valid  out  1      S/carry_out hold a completed result
//  out_ready  in   1      consumer takes the result (transfer = out_valid & out_ready)
//  S          out  WIDTH  result, mod 2^WIDTH
//  carry_out  out  1      add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
// BEHAVIOUR
//  - Reset (Rst=1 at posedge): all stage valid bits, out_valid, S, carry_out and inter-stage carries clear to 0.
//    in_ready is 1 in the cycle after reset is released. A reset applied mid-stream discards all in-flight transactions.
//  - Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational). When adv=0 every stage register holds.
//  - Sub mode: B is inverted at entry and segment 0 receives carry-in = 1. Add mode: carry-in = 0.
//    in_sub travels with the data in a per-stage mode bit.
//  - Stage k (0..NSEG-1) computes SEG_W-bit segment k, using carry from stage k-1 of the SAME transaction.
//    Segments j>k of A/B' are carried in a shrinking delay line. Segments j<k already computed are carried in a growing result line.
//  - Latency: pair accepted at edge t -> out_valid=1 after edge t+NSEG when there is no stall. Throughput 1/cycle. Results are in order.
//  - Bubbles (in_valid=0) propagate as invalid stages. Data registers of invalid stages may hold any value.
//    S and carry_out are only meaningful when out_valid=1.
//  - While out_valid & ~out_ready: S, carry_out and out_valid are stable. No transaction is lost or duplicated.
//  - Wrap-around: all-ones + 1 -> S=0, carry_out=1. 0 - 1 -> S=all-ones, carry_out=0.
//  - in_valid with in_ready=0 is not accepted. The source holds its inputs, and no internal copy is taken.
//  - Simultaneous out transfer and in transfer in the same cycle is legal and keeps full throughput.
//  - NSEG=1: single-stage registered add/sub, latency 1.
// STRUCTURE
//  - ibr_pkg: typedef enum logic {IBR_ADD=1'b0, IBR_SUB=1'b1} ibr_op_e; default localparams IBR_WIDTH=128, IBR_SEG_W=16.
//  - Sub-module ibr_addsub_seg: one pipeline stage.
//    Inputs: SEG_W-bit a/b segments, cin, valid, adv. Outputs: registered sum segment, cout, valid.
//    Instantiated NSEG times in a generate loop.
//  - Operand delay lines and result alignment are kept in the top level. No latches and no async logic.
// TESTING (default WIDTH=128, SEG_W=16, NSEG=8)
//  1. add all-ones(128) + 1, out_ready=1 -> 8 cycles later out_valid=1, S=0, carry_out=1.
//  2. sub 0 - 1 -> S=128'hFFFF...FFFF, carry_out=0. Sub 5 - 3 -> S=2, carry_out=1.
//  3. Burst of 64 back-to-back random pairs with mixed in_sub -> 64 results, in order, matching a reference model.
//     Exactly 1 result per cycle after the 8-cycle fill.
//  4. During a burst, out_ready=0 for 3 cycles -> in_ready=0 for those cycles and S held stable.
//     The stream resumes with no loss or duplication.
//  5. Rst pulsed 1 cycle with 5 transactions in flight -> next cycle out_valid=0, S=0.
//     New pair 7+9 -> S=16 after 8 cycles, and no stale results appear.
//  6. Re-run 1-3 with WIDTH=64, SEG_W=32 (latency 2) and WIDTH=32, SEG_W=32 (latency 1). Same pass criteria.

Source files
------------

// File: rtl/ibr_pkg.sv
// rtl/ibr_pkg.sv - shared types and default sizes for the segmented add/sub pipeline
// Purpose: operation encoding and default datapath geometry used by ibr_pipe_addsub
//          and its per-segment stage ibr_addsub_seg.
// Contents: ibr_op_e (add/sub mode bit), IBR_WIDTH, IBR_SEG_W.
package ibr_pkg;

   typedef enum logic {
      IBR_ADD = 1'b0,
      IBR_SUB = 1'b1
   } ibr_op_e;

   localparam int IBR_WIDTH = 128;
   localparam int IBR_SEG_W = 16;

endpackage

// File: rtl/ibr_addsub_seg.sv
// rtl/ibr_addsub_seg.sv - one carry-segmented pipeline stage (SEG_W-bit add with carry)
// Purpose: adds one SEG_W-bit segment of A and B' plus the carry from the previous
//          segment of the same transaction, and registers sum, carry and valid.
// Ports:
//    Clk      in   clock, posedge
//    Rst      in   synchronous active-high reset
//    adv_i    in   global pipeline advance; stage holds when low
//    valid_i  in   incoming transaction valid
//    a_i      in   SEG_W-bit operand A segment
//    b_i      in   SEG_W-bit operand B segment (already inverted for subtract)
//    cin_i    in   carry into this segment
//    sum_o    out  registered SEG_W-bit sum segment
//    cout_o   out  registered carry out of this segment
//    valid_o  out  registered valid
module ibr_addsub_seg
   import ibr_pkg::*;
#(
   parameter int SEG_W = IBR_SEG_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             adv_i,
   input  logic             valid_i,
   input  logic [SEG_W-1:0] a_i,
   input  logic [SEG_W-1:0] b_i,
   input  logic             cin_i,
   output logic [SEG_W-1:0] sum_o,
   output logic             cout_o,
   output logic             valid_o
);

   logic [SEG_W:0]   tot_d;
   logic [SEG_W-1:0] sum_q;
   logic             cout_q;
   logic             valid_q;

   always_comb begin
      tot_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (adv_i) begin
         sum_q   <= tot_d[SEG_W-1:0];
         cout_q  <= tot_d[SEG_W];
         valid_q <= valid_i;
      end
   end

   assign sum_o   = sum_q;
   assign cout_o  = cout_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ibr_pipe_addsub.sv
// rtl/ibr_pipe_addsub.sv - carry-segmented pipelined adder/subtractor with valid/ready
// Purpose: S = A + B or A - B (mod 2^WIDTH), one pair per cycle, NSEG = WIDTH/SEG_W
//          stages, one SEG_W-bit segment resolved per stage. A single advance signal
//          stalls the whole pipeline under output backpressure.
// Ports:
//    Clk        in   clock, posedge
//    Rst        in   synchronous active-high reset
//    in_valid   in   operand pair valid
//    in_ready   out  pair accepted this cycle when in_valid is high
//    in_sub     in   0: add, 1: subtract
//    A, B       in   WIDTH-bit operands
//    out_valid  out  S/carry_out hold a completed result
//    out_ready  in   consumer takes the result
//    S          out  WIDTH-bit result
//    carry_out  out  add: carry out of MSB; sub: 1 = no borrow
module ibr_pipe_addsub
   import ibr_pkg::*;
#(
   parameter int WIDTH = IBR_WIDTH,
   parameter int SEG_W = IBR_SEG_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             carry_out
);

   localparam int NSEG = WIDTH / SEG_W;

   logic             adv;
   logic [SEG_W-1:0] seg_sum  [NSEG];
   logic             seg_cout [NSEG];
   logic             seg_vld  [NSEG];

   // Operand delay line: opa_q[k]/opb_q[k] feed stage k+1; only segments above k
   // are still needed, so lower bits are dead and trimmed by synthesis.
   logic [WIDTH-1:0] opa_q  [NSEG];
   logic [WIDTH-1:0] opb_q  [NSEG];
   ibr_op_e          mode_q [NSEG];
   // Result line: res_q[k] holds finished segments 0..k-1 alongside stage k.
   logic [WIDTH-1:0] res_q  [NSEG];

   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = seg_vld[NSEG-1];
   assign carry_out = seg_cout[NSEG-1];

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [SEG_W-1:0] b_seg;
      ibr_op_e          mode;
      logic             cin;
      logic             vin;

      if (k == 0) begin : g_first
         assign a_in = A;
         assign b_in = B;
         assign mode = ibr_op_e'(in_sub);
         // Two's-complement subtract: ~B plus carry-in 1 at the bottom segment.
         assign cin  = in_sub;
         assign vin  = in_valid;
      end else begin : g_next
         assign a_in = opa_q[k-1];
         assign b_in = opb_q[k-1];
         assign mode = mode_q[k-1];
         assign cin  = seg_cout[k-1];
         assign vin  = seg_vld[k-1];
      end

      // The travelling mode bit inverts each B segment as it reaches its stage,
      // which is equivalent to inverting the whole word on entry.
      assign b_seg = (mode == IBR_SUB) ? ~b_in[k*SEG_W +: SEG_W] : b_in[k*SEG_W +: SEG_W];

      ibr_addsub_seg #(
         .SEG_W (SEG_W)
      ) u_seg (
         .Clk     (Clk),
         .Rst     (Rst),
         .adv_i   (adv),
         .valid_i (vin),
         .a_i     (a_in[k*SEG_W +: SEG_W]),
         .b_i     (b_seg),
         .cin_i   (cin),
         .sum_o   (seg_sum[k]),
         .cout_o  (seg_cout[k]),
         .valid_o (seg_vld[k])
      );

      if (k < NSEG-1) begin : g_opline
         always_ff @(posedge Clk) begin
            if (adv) begin
               opa_q[k]  <= a_in;
               opb_q[k]  <= b_in;
               mode_q[k] <= mode;
            end
         end
      end

      if (k > 0) begin : g_resline
         always_ff @(posedge Clk) begin
            if (Rst) begin
               res_q[k] <= '0;
            end else if (adv) begin
               res_q[k] <= (k == 1) ? '0 : res_q[k-1];
               res_q[k][(k-1)*SEG_W +: SEG_W] <= seg_sum[k-1];
            end
         end
      end
   end

   for (genvar j = 0; j < NSEG; j++) begin : g_out
      if (j == NSEG-1) begin : g_top_seg
         assign S[j*SEG_W +: SEG_W] = seg_sum[NSEG-1];
      end else begin : g_low_seg
         assign S[j*SEG_W +: SEG_W] = res_q[NSEG-1][j*SEG_W +: SEG_W];
      end
   end

endmodule

// File: tb/tb_ibr_pipe_addsub.sv
// tb/tb_ibr_pipe_addsub.sv - bench for ibr_pipe_addsub at 128/16, 64/32 and 32/32
module tb_ibr_pipe_addsub;

   typedef struct {
      logic         sub;
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] es;
      logic [2:0]   ec;   // [0]=WIDTH 128, [1]=WIDTH 64, [2]=WIDTH 32
   } vec_t;

   typedef struct {
      logic [127:0] s;
      logic         c;
      int           t;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_v;
   logic         sub_r;
   logic [127:0] a_r;
   logic [127:0] b_r;
   logic         ordy;
   logic [2:0]   iv, ir, ov, co;
   logic [127:0] s0;
   logic [63:0]  s1;
   logic [31:0]  s2;

   int           sel;
   int           lat;
   int           wid;
   int           cyc;
   int           n_cmp;
   int           n_fail;
   int           stray;
   int           stall_from;
   bit           chk_lat;
   logic         prev_hold;
   logic [127:0] prev_s;
   logic         prev_c;
   exp_t         q[$];
   vec_t         vt[10];

   logic [127:0] s_sel;
   logic         ov_sel, ir_sel, co_sel;

   always #5 clk = ~clk;

   assign iv = {in_v && (sel == 2), in_v && (sel == 1), in_v && (sel == 0)};

   ibr_pipe_addsub #(.WIDTH(128), .SEG_W(16)) u_w128 (
      .Clk(clk), .Rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_sub(sub_r),
      .A(a_r), .B(b_r), .out_valid(ov[0]), .out_ready(ordy), .S(s0), .carry_out(co[0]));

   ibr_pipe_addsub #(.WIDTH(64), .SEG_W(32)) u_w64 (
      .Clk(clk), .Rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_sub(sub_r),
      .A(a_r[63:0]), .B(b_r[63:0]), .out_valid(ov[1]), .out_ready(ordy), .S(s1), .carry_out(co[1]));

   ibr_pipe_addsub #(.WIDTH(32), .SEG_W(32)) u_w32 (
      .Clk(clk), .Rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_sub(sub_r),
      .A(a_r[31:0]), .B(b_r[31:0]), .out_valid(ov[2]), .out_ready(ordy), .S(s2), .carry_out(co[2]));

   always_comb begin
      s_sel  = '0;
      ov_sel = 1'b0;
      ir_sel = 1'b0;
      co_sel = 1'b0;
      case (sel)
         0:       begin s_sel = s0;            ov_sel = ov[0]; ir_sel = ir[0]; co_sel = co[0]; end
         1:       begin s_sel = {64'd0, s1};   ov_sel = ov[1]; ir_sel = ir[1]; co_sel = co[1]; end
         default: begin s_sel = {96'd0, s2};   ov_sel = ov[2]; ir_sel = ir[2]; co_sel = co[2]; end
      endcase
   end

   task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (width %0d, cycle %0d): got %h, want %h", name, wid, cyc, act, exp);
      end
   endtask

   function automatic logic [127:0] trunc(input logic [127:0] x, input int w);
      logic [128:0] m;
      m = (129'd1 << w) - 129'd1;
      return x & m[127:0];
   endfunction

   // Reference: result in [127:0], carry/no-borrow in [128].
   function automatic logic [128:0] model(input logic sub, input logic [127:0] a,
                                          input logic [127:0] b, input int w);
      logic [128:0] m, aa, bb, r;
      logic         c;
      m  = (129'd1 << w) - 129'd1;
      aa = {1'b0, a} & m;
      bb = {1'b0, b} & m;
      if (sub) begin
         c = (aa >= bb);
         r = (aa - bb) & m;
      end else begin
         r = aa + bb;
         c = r[w];
         r = r & m;
      end
      r[128] = c;
      return r;
   endfunction

   // One clock cycle: drive at negedge, check settled outputs, record acceptance.
   task automatic cycle(input logic v, input logic sub, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] es, input logic ec,
                        input logic r, output logic acc);
      exp_t e;
      @(negedge clk);
      rst   = r;
      in_v  = v;
      sub_r = sub;
      a_r   = a;
      b_r   = b;
      ordy  = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 3);
      #1;
      acc = 1'b0;
      if (r) begin
         q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_out_valid", ov_sel, 1);
            chk("hold_s", s_sel, prev_s);
            chk("hold_carry", co_sel, prev_c);
         end
         if (ov_sel && !ordy) chk("stall_in_ready", ir_sel, 0);
         if (ov_sel && ordy) begin
            chk("result_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("result_s", s_sel, e.s);
               chk("result_carry", co_sel, e.c);
               if (chk_lat) chk("latency", cyc - e.t, lat);
            end
         end
         if (v && ir_sel) begin
            acc = 1'b1;
            e.s = es;
            e.c = ec;
            e.t = cyc;
            q.push_back(e);
         end
         prev_hold = ov_sel && !ordy;
         prev_s    = s_sel;
         prev_c    = co_sel;
      end
      for (int k = 0; k < 3; k++)
         if (k != sel && ov[k]) stray++;
      cyc++;
   endtask

   task automatic send(input logic sub, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] es, input logic ec);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
         cycle(1'b1, sub, a, b, es, ec, 1'b0, acc);
         tries++;
      end
      chk("accept", acc, 1);
   endtask

   task automatic send_rand();
      logic         sub;
      logic [127:0] a, b;
      logic [128:0] m;
      sub = 1'($urandom_range(0, 1));
      a   = {$urandom(), $urandom(), $urandom(), $urandom()};
      b   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = model(sub, a, b, wid);
      send(sub, a, b, m[127:0], m[128]);
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
         n++;
      end
      chk("drain_empty", q.size(), 0);
      repeat (10) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
   endtask

   initial begin
      logic         acc;
      logic [127:0] ones;
      ones = '1;
      vt[0] = '{1'b0, ones,        128'd1, 128'd0, 3'b111};
      vt[1] = '{1'b1, 128'd0,      128'd1, ones,   3'b000};
      vt[2] = '{1'b1, 128'd5,      128'd3, 128'd2, 3'b111};
      vt[3] = '{1'b0, 128'd7,      128'd9, 128'd16, 3'b000};
      vt[4] = '{1'b0, 128'hFFFF_FFFF, 128'd1, 128'h1_0000_0000, 3'b100};
      vt[5] = '{1'b1, 128'h1_0000_0000, 128'd1, 128'hFFFF_FFFF, 3'b011};
      vt[6] = '{1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'd0, 3'b111};
      vt[7] = '{1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                      128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd0, 3'b001};
      vt[8] = '{1'b1, 128'd3, 128'd5, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 3'b000};
      vt[9] = '{1'b0, 128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
                      128'h0001_0000_0000_0000_0000_0000_0000_0000, 3'b110};

      n_cmp = 0; n_fail = 0; stray = 0; cyc = 0; stall_from = -1;
      prev_hold = 1'b0; prev_s = '0; prev_c = 1'b0; chk_lat = 1'b1;
      sel = 0; wid = 128; lat = 8;
      rst = 1'b1; in_v = 1'b0; sub_r = 1'b0; a_r = '0; b_r = '0; ordy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset_out_valid", ov[k], 0);
         chk("reset_carry", co[k], 0);
         chk("reset_in_ready", ir[k], 1);
      end
      chk("reset_s128", s0, 0);
      chk("reset_s64", s1, 0);
      chk("reset_s32", s2, 0);

      for (int s = 0; s < 3; s++) begin
         sel = s;
         wid = (s == 0) ? 128 : (s == 1) ? 64 : 32;
         lat = (s == 0) ? 8 : (s == 1) ? 2 : 1;
         chk_lat = 1'b1;
         foreach (vt[i]) send(vt[i].sub, vt[i].a, vt[i].b, trunc(vt[i].es, wid), vt[i].ec[s]);
         drain();
         repeat (64) send_rand();
         drain();
         chk_lat = 1'b0;
         stall_from = cyc + 12;
         repeat (24) send_rand();
         drain();
         stall_from = -1;
      end

      sel = 0; wid = 128; lat = 8; chk_lat = 1'b1;
      repeat (5) send_rand();
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
      chk("post_reset_out_valid", ov[0], 0);
      chk("post_reset_s", s0, 0);
      send(1'b0, 128'd7, 128'd9, 128'd16, 1'b0);
      drain();

      chk("stray_out_valid", stray, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
